// File: rtl/rvvi_retire_sequencer.sv
// Collects retire/trap records into per-hart retirement slots and emits a
// bundle on EOL. Ports: in_* record stream, out_* flattened bundle, err.
module rvvi_retire_sequencer #(
  parameter int NHART  = 1,
  parameter int RETIRE = 2,
  parameter int XLEN   = 64,
  parameter int ILEN   = 32,
  parameter int ORDERW = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0]                       in_kind,
  input  logic [63:0]                      in_data,
  input  logic [ILEN-1:0]                  in_insn,
  output logic                             out_strobe,
  input  logic                             out_ack,
  output logic [NHART*RETIRE-1:0]          out_valid,
  output logic [NHART*RETIRE-1:0]          out_trap,
  output logic [NHART*RETIRE*XLEN-1:0]     out_pc,
  output logic [NHART*RETIRE*ILEN-1:0]     out_insn,
  output logic [NHART*RETIRE*ORDERW-1:0]   out_order,
  output logic                             err,
  output logic [1:0]                       err_code
);

  localparam int NS = NHART * RETIRE;
  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;

  localparam logic [2:0] K_RET   = 3'd0;
  localparam logic [2:0] K_TRAP  = 3'd1;
  localparam logic [2:0] K_HART  = 3'd2;
  localparam logic [2:0] K_ISSUE = 3'd3;
  localparam logic [2:0] K_ORDER = 3'd4;
  localparam logic [2:0] K_EOL   = 3'd5;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t            state;
  logic [HW-1:0]     cur_hart;
  logic [31:0]       slot;
  logic              ainc;
  logic [ORDERW-1:0] order_q [NHART];

  logic              xfer;
  logic              is_rec;
  logic [31:0]       s;
  logic [31:0]       idx;
  logic              in_rng;
  logic              hit;
  logic              hart_ok;
  logic [ORDERW-1:0] cur_ord;
  logic [1:0]        ecode;

  assign in_ready   = (state == ACCUM);
  assign out_strobe = (state == EMIT);
  assign xfer       = in_valid && in_ready;
  assign is_rec     = (in_kind == K_RET) || (in_kind == K_TRAP);
  assign s          = slot + {31'b0, ainc};
  assign in_rng     = s < 32'(RETIRE);
  assign idx        = 32'(cur_hart) * 32'(RETIRE) + s;
  assign hart_ok    = in_data < 64'(NHART);

  // Loops instead of variable indexing keep every select in range.
  always_comb begin
    cur_ord = '0;
    for (int h = 0; h < NHART; h++)
      if (cur_hart == HW'(h)) cur_ord = order_q[h];
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (in_rng && idx == 32'(i)) hit = out_valid[i];
  end

  always_comb begin
    ecode = 2'd0;
    case (in_kind)
      K_RET, K_TRAP: begin
        if (!in_rng)  ecode = 2'd2;
        else if (hit) ecode = 2'd1;
      end
      K_HART:  if (!hart_ok) ecode = 2'd3;
      K_ISSUE, K_ORDER, K_EOL: ecode = 2'd0;
      default: ecode = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cur_hart  <= '0;
      slot      <= '0;
      ainc      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      out_valid <= '0;
      out_trap  <= '0;
      out_pc    <= '0;
      out_insn  <= '0;
      out_order <= '0;
      for (int h = 0; h < NHART; h++)
        order_q[h] <= '0;
    end else begin
      if (xfer && ecode != 2'd0 && !err) begin
        err      <= 1'b1;
        err_code <= ecode;
      end
      case (state)
        ACCUM: begin
          if (xfer) begin
            case (in_kind)
              K_HART: begin
                if (hart_ok) begin
                  cur_hart <= HW'(in_data);
                  slot     <= '0;
                  ainc     <= 1'b0;
                end
              end
              K_ISSUE: begin
                slot <= in_data[31:0];
                ainc <= 1'b0;
              end
              K_ORDER: begin
                for (int h = 0; h < NHART; h++)
                  if (cur_hart == HW'(h))
                    order_q[h] <= ORDERW'(in_data);
              end
              K_RET, K_TRAP: begin
                slot <= s;
                ainc <= 1'b1;
                // Dropped records still consume an order number.
                for (int h = 0; h < NHART; h++)
                  if (cur_hart == HW'(h))
                    order_q[h] <= order_q[h] + ORDERW'(1);
                if (ecode == 2'd0) begin
                  for (int i = 0; i < NS; i++) begin
                    if (idx == 32'(i)) begin
                      out_valid[i] <= 1'b1;
                      out_trap[i]  <= (in_kind == K_TRAP);
                      out_pc[i*XLEN +: XLEN]       <= XLEN'(in_data);
                      out_insn[i*ILEN +: ILEN]     <= in_insn;
                      out_order[i*ORDERW +: ORDERW] <= cur_ord;
                    end
                  end
                end
              end
              K_EOL: begin
                slot <= '0;
                ainc <= 1'b0;
                if (|out_valid) state <= EMIT;
              end
              default: ;
            endcase
          end
        end
        EMIT: begin
          if (out_ack) begin
            out_valid <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  logic unused;
  assign unused = is_rec;

endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// Directed bench for rvvi_retire_sequencer with a bundle scoreboard.
// NHART=2, RETIRE=2 so hart selection and slot errors are reachable.
module tb_rvvi_retire_sequencer;

  localparam int NHART  = 2;
  localparam int RETIRE = 2;
  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int ORDERW = 64;
  localparam int NS     = NHART * RETIRE;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [2:0]              in_kind = '0;
  logic [63:0]             in_data = '0;
  logic [ILEN-1:0]         in_insn = '0;
  logic                    out_strobe;
  logic                    out_ack = 1'b0;
  logic [NS-1:0]           out_valid;
  logic [NS-1:0]           out_trap;
  logic [NS*XLEN-1:0]      out_pc;
  logic [NS*ILEN-1:0]      out_insn;
  logic [NS*ORDERW-1:0]    out_order;
  logic                    err;
  logic [1:0]              err_code;

  rvvi_retire_sequencer #(
    .NHART(NHART), .RETIRE(RETIRE), .XLEN(XLEN),
    .ILEN(ILEN), .ORDERW(ORDERW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_data(in_data), .in_insn(in_insn),
    .out_strobe(out_strobe), .out_ack(out_ack),
    .out_valid(out_valid), .out_trap(out_trap),
    .out_pc(out_pc), .out_insn(out_insn), .out_order(out_order),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0]             v;
    logic [NS-1:0]             t;
    logic [NS-1:0][XLEN-1:0]   pc;
    logic [NS-1:0][ILEN-1:0]   insn;
    logic [NS-1:0][ORDERW-1:0] ord;
  } bundle_t;

  bundle_t sb[$];
  bundle_t cur;
  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [2:0] k, input logic [63:0] d,
                      input logic [31:0] ins);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("ready_timeout", 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    in_kind  = k;
    in_data  = d;
    in_insn  = ins;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_bundle();
    cur = '0;
  endtask

  task automatic expect_slot(input int i, input logic t,
                             input logic [63:0] pc, input logic [31:0] ins,
                             input logic [63:0] ord);
    cur.v[i]    = 1'b1;
    cur.t[i]    = t;
    cur.pc[i]   = pc;
    cur.insn[i] = ins;
    cur.ord[i]  = ord;
  endtask

  task automatic eol(input logic emit);
    send(3'd5, 64'd0, 32'd0);
    chk("eol_latency", 256'(out_strobe), 256'(emit));
    if (emit) sb.push_back(cur);
  endtask

  task automatic check_bundle(input int hold);
    bundle_t e;
    int n;
    n = 0;
    while (!out_strobe && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("strobe", 256'(out_strobe), 256'(1));
    if (sb.size() == 0) begin
      chk("sb_empty", 256'(0), 256'(1));
    end else begin
      e = sb.pop_front();
      chk("valid", 256'(out_valid), 256'(e.v));
      chk("trap", 256'(out_trap & e.v), 256'(e.t));
      for (int i = 0; i < NS; i++) begin
        if (e.v[i]) begin
          chk("pc", 256'(out_pc[i*XLEN +: XLEN]), 256'(e.pc[i]));
          chk("insn", 256'(out_insn[i*ILEN +: ILEN]), 256'(e.insn[i]));
          chk("order", 256'(out_order[i*ORDERW +: ORDERW]), 256'(e.ord[i]));
        end
      end
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #1;
        chk("bp_ready", 256'(in_ready), 256'(0));
        chk("bp_strobe", 256'(out_strobe), 256'(1));
        chk("bp_valid", 256'(out_valid), 256'(e.v));
        for (int i = 0; i < NS; i++)
          if (e.v[i])
            chk("bp_order", 256'(out_order[i*ORDERW +: ORDERW]),
                256'(e.ord[i]));
      end
    end
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    chk("ack_ready", 256'(in_ready), 256'(1));
    chk("ack_strobe", 256'(out_strobe), 256'(0));
    chk("ack_valid", 256'(out_valid), 256'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_ready", 256'(in_ready), 256'(1));
    chk("rst_strobe", 256'(out_strobe), 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_pc", 256'(out_pc), 256'(0));
    chk("rst_order", 256'(out_order), 256'(0));
    chk("rst_err", 256'({err, err_code}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single record
    start_bundle();
    send(3'd4, 64'd5, 32'd0);
    send(3'd0, 64'h8000_0000, 32'h0000_0013);
    expect_slot(0, 1'b0, 64'h8000_0000, 32'h0000_0013, 64'd5);
    eol(1'b1);
    check_bundle(0);

    // out_ack in ACCUM ignored, empty EOL does not emit
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    eol(1'b0);
    chk("empty_eol_ready", 256'(in_ready), 256'(1));

    // dual issue, order continues at 6, with backpressure
    start_bundle();
    send(3'd0, 64'h1000, 32'h1111_1111);
    send(3'd1, 64'h2000, 32'h2222_2222);
    expect_slot(0, 1'b0, 64'h1000, 32'h1111_1111, 64'd6);
    expect_slot(1, 1'b1, 64'h2000, 32'h2222_2222, 64'd7);
    eol(1'b1);
    check_bundle(10);

    // hart 1 slot 1 only
    start_bundle();
    send(3'd2, 64'd1, 32'd0);
    send(3'd3, 64'd1, 32'd0);
    send(3'd0, 64'h3000, 32'h3333_3333);
    expect_slot(3, 1'b0, 64'h3000, 32'h3333_3333, 64'd0);
    eol(1'b1);
    check_bundle(0);

    // hart 0 order untouched at 8
    start_bundle();
    send(3'd2, 64'd0, 32'd0);
    send(3'd0, 64'h4000, 32'h4444_4444);
    expect_slot(0, 1'b0, 64'h4000, 32'h4444_4444, 64'd8);
    eol(1'b1);
    check_bundle(0);
    chk("no_err_yet", 256'(err), 256'(0));

    // three RETs: third out of range
    start_bundle();
    send(3'd0, 64'h5000, 32'h5);
    send(3'd0, 64'h5004, 32'h6);
    send(3'd0, 64'h5008, 32'h7);
    expect_slot(0, 1'b0, 64'h5000, 32'h5, 64'd9);
    expect_slot(1, 1'b0, 64'h5004, 32'h6, 64'd10);
    eol(1'b1);
    chk("range_err", 256'({err, err_code}), 256'({1'b1, 2'd2}));
    check_bundle(0);
    start_bundle();
    send(3'd0, 64'h6000, 32'h8);
    expect_slot(0, 1'b0, 64'h6000, 32'h8, 64'd12);
    eol(1'b1);
    check_bundle(0);

    // collision
    do_reset();
    chk("rst2_err", 256'({err, err_code}), 256'(0));
    start_bundle();
    send(3'd3, 64'd0, 32'd0);
    send(3'd0, 64'h7000, 32'h9);
    send(3'd3, 64'd0, 32'd0);
    send(3'd0, 64'h7100, 32'ha);
    expect_slot(0, 1'b0, 64'h7000, 32'h9, 64'd0);
    eol(1'b1);
    chk("coll_err", 256'({err, err_code}), 256'({1'b1, 2'd1}));
    check_bundle(0);
    start_bundle();
    send(3'd0, 64'h7200, 32'hb);
    expect_slot(0, 1'b0, 64'h7200, 32'hb, 64'd2);
    eol(1'b1);
    check_bundle(0);

    // bad hart: no state change, then first code sticks
    do_reset();
    start_bundle();
    send(3'd2, 64'd4, 32'd0);
    chk("hart_err", 256'({err, err_code}), 256'({1'b1, 2'd3}));
    send(3'd0, 64'h8000, 32'hc);
    expect_slot(0, 1'b0, 64'h8000, 32'hc, 64'd0);
    send(3'd0, 64'h8004, 32'hd);
    send(3'd0, 64'h8008, 32'he);
    expect_slot(1, 1'b0, 64'h8004, 32'hd, 64'd1);
    eol(1'b1);
    chk("err_sticky", 256'({err, err_code}), 256'({1'b1, 2'd3}));
    check_bundle(0);

    // async reset during EMIT
    do_reset();
    send(3'd4, 64'd40, 32'd0);
    send(3'd1, 64'h9000, 32'hf);
    eol(1'b1);
    void'(sb.pop_back());
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_strobe", 256'(out_strobe), 256'(0));
    chk("arst_ready", 256'(in_ready), 256'(1));
    chk("arst_valid", 256'({out_valid, out_trap}), 256'(0));
    chk("arst_pc", 256'(out_pc), 256'(0));
    chk("arst_insn", 256'(out_insn), 256'(0));
    chk("arst_order", 256'(out_order), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // illegal kind, then order counter back to 0
    send(3'd6, 64'd0, 32'd0);
    chk("kind_err", 256'({err, err_code}), 256'({1'b1, 2'd3}));
    start_bundle();
    send(3'd0, 64'ha000, 32'h10);
    expect_slot(0, 1'b0, 64'ha000, 32'h10, 64'd0);
    eol(1'b1);
    check_bundle(0);
    chk("sb_drained", 256'(sb.size()), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
